logic_axi4_stream_downsizer: RTL and testbench
==============================================

# logic_axi4_stream_downsizer

AXI4-Stream width converter that accepts wide words on an RX interface and re-emits them as a sequence of narrower words on a TX interface, LSB slice first. It is the reading/unpacking end paired with the team's stream upsizer, and sits between wide datapath blocks and narrow sinks such as bus bridges and serial transmitters. The block holds one wide word in a skid-free output buffer and sustains one output slice per clock.

## Interface
- TARGET, logic_pkg::TARGET_GENERIC, implementation target (logic_pkg::target_t); no behavioural difference for any value.
- TDATA_BYTES_IN, 8, RX tdata width in bytes.
- TDATA_BYTES_OUT, 2, TX tdata width in bytes.
- TUSER_WIDTH, 1, tuser width in bits, passed through.
- RATIO (localparam) = TDATA_BYTES_IN / TDATA_BYTES_OUT; elaboration error unless it is an integer ≥ 2.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- areset  input  1  synchronous, active-high reset.
- rx_tvalid  input  1  input word valid.
- rx_tready  output  1  input word accepted when high together with rx_tvalid.
- rx_tdata  input  8*TDATA_BYTES_IN  input data.
- rx_tkeep  input  TDATA_BYTES_IN  byte qualifiers.
- rx_tlast  input  1  end of packet.
- rx_tuser  input  TUSER_WIDTH  sideband.
- tx_tvalid  output  1  output slice valid.
- tx_tready  input  1  sink ready.
- tx_tdata  output  8*TDATA_BYTES_OUT  output data.
- tx_tkeep  output  TDATA_BYTES_OUT  byte qualifiers.
- tx_tlast  output  1  end of packet.
- tx_tuser  output  TUSER_WIDTH  sideband.

## Operation
- Buffer registers: data, keep, last, user, slice index idx (clog2(RATIO) bits), valid flag.
- States: EMPTY (valid=0), EMIT (valid=1).
- Final slice index F = highest slice whose keep bits are nonzero; F = 0 if rx_tkeep is all zero.
- EMPTY: rx_tready=1; on rx_tvalid load buffer, idx=0, F computed at load and stored, go to EMIT.
- EMIT: tx_tdata = data[idx*8*TDATA_BYTES_OUT +: 8*TDATA_BYTES_OUT]; tx_tkeep = matching keep slice; tx_tuser = stored user on every slice; tx_tlast = stored last && idx==F.
- Slices below F are emitted even when their keep is zero (null slices, tkeep=0). Slices above F are never emitted.
- On tx handshake with idx<F: idx+1. With idx==F: rx_tready=1 in the same cycle; if rx_tvalid, load the new word (idx=0, stay EMIT); else go EMPTY.
- rx_tready = areset ? 0 : (!valid || (tx_tready && idx==F)); combinational from tx_tready.
- Buffer holds stable while tx_tvalid && !tx_tready (AXI4-Stream stability rule).

## Timing
- Reset: tx_tvalid=0, tx_tdata=0, tx_tkeep=0, tx_tlast=0, tx_tuser=0, idx=0, rx_tready=0 while areset high, 1 on the first cycle after.
- Latency: slice 0 appears on TX one cycle after the RX handshake.
- Throughput: F+1 cycles per input word with tx_tready constantly high; no bubble between words.
- Reset mid-word: buffered word discarded, no further slices, outputs return to reset values the next cycle.
- Simultaneous final-slice handshake and new RX word: both complete in the same cycle.

## Test plan
- RATIO=4, rx word 0x8877_6655_4433_2211, tkeep 0xFF, tlast=1 -> tx 0x2211, 0x4433, 0x6655, 0x8877 on consecutive cycles, tkeep 0x3 each, tlast only on 0x8877.
- rx tkeep 0x0F, tlast=1 -> exactly 2 slices, tlast on 2nd, tkeep 0x3, 0x3.
- rx tkeep 0x00, tlast=1 -> single slice, tkeep 0, tlast=1.
- Three back-to-back full words, tx_tready=1 -> 12 contiguous slices, rx_tready high only on cycles 4, 8, 12 after the first accept.
- tx_tready toggled randomly -> tx_tdata/tkeep/tlast/tuser stable while stalled, slice order preserved, tuser 0x1 repeated on all slices.
- areset asserted after slice 1 of a word -> tx_tvalid=0 next cycle, no remaining slices, next word starts at slice 0.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared type definitions for the logic_* stream blocks.
package logic_pkg;

  // Implementation target; selects vendor-specific structures where a block has any.
  typedef enum logic [1:0] {
    TARGET_GENERIC = 2'd0,
    TARGET_XILINX  = 2'd1,
    TARGET_INTEL   = 2'd2
  } target_t;

endpackage

// File: rtl/logic_axi4_stream_downsizer.sv
// AXI4-Stream downsizer: buffers one wide RX word and re-emits it as a run of
// narrow TX slices, LSB slice first. Slices above the highest slice carrying
// nonzero tkeep are skipped; null slices below it are still emitted.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   rx_t{valid,ready,data,keep,last,user}   wide input stream
//   tx_t{valid,ready,data,keep,last,user}   narrow output stream
// tx_* are driven straight from the buffer registers; rx_tready is
// combinational from tx_tready so a new word loads while the last slice leaves.
module logic_axi4_stream_downsizer
  import logic_pkg::*;
#(
  parameter target_t     TARGET          = TARGET_GENERIC,
  parameter int unsigned TDATA_BYTES_IN  = 8,
  parameter int unsigned TDATA_BYTES_OUT = 2,
  parameter int unsigned TUSER_WIDTH     = 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         rx_tvalid,
  output logic                         rx_tready,
  input  logic [8*TDATA_BYTES_IN-1:0]  rx_tdata,
  input  logic [TDATA_BYTES_IN-1:0]    rx_tkeep,
  input  logic                         rx_tlast,
  input  logic [TUSER_WIDTH-1:0]       rx_tuser,
  output logic                         tx_tvalid,
  input  logic                         tx_tready,
  output logic [8*TDATA_BYTES_OUT-1:0] tx_tdata,
  output logic [TDATA_BYTES_OUT-1:0]   tx_tkeep,
  output logic                         tx_tlast,
  output logic [TUSER_WIDTH-1:0]       tx_tuser
);

  localparam int unsigned RATIO  = TDATA_BYTES_IN / TDATA_BYTES_OUT;
  localparam int unsigned IN_W   = 8 * TDATA_BYTES_IN;
  localparam int unsigned OUT_W  = 8 * TDATA_BYTES_OUT;
  localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Parameter sanity checks at elaboration.
  if ((TDATA_BYTES_OUT == 0) || (TDATA_BYTES_IN % TDATA_BYTES_OUT != 0) || (RATIO < 2)) begin : g_bad_ratio
    $error("logic_axi4_stream_downsizer: TDATA_BYTES_IN / TDATA_BYTES_OUT must be an integer >= 2");
  end
  if ((TARGET != TARGET_GENERIC) && (TARGET != TARGET_XILINX) && (TARGET != TARGET_INTEL)) begin : g_bad_target
    $error("logic_axi4_stream_downsizer: unknown TARGET");
  end

  typedef enum logic {EMPTY, EMIT} state_t;

  state_t                   state_q, state_d;
  logic [IN_W-1:0]          data_q, data_d;
  logic [TDATA_BYTES_IN-1:0] keep_q, keep_d;
  logic                     last_q, last_d;
  logic [TUSER_WIDTH-1:0]   user_q, user_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         fin_q, fin_d;
  logic [IDX_W-1:0]         fin_c;
  logic                     rx_tready_c;

  // Slice views of the buffer and of the incoming keep.
  logic [RATIO-1:0][OUT_W-1:0]           data_s;
  logic [RATIO-1:0][TDATA_BYTES_OUT-1:0] keep_s;
  logic [RATIO-1:0][TDATA_BYTES_OUT-1:0] rx_keep_s;

  assign data_s    = data_q;
  assign keep_s    = keep_q;
  assign rx_keep_s = rx_tkeep;

  // Final slice of the incoming word: highest slice with any keep bit set.
  always_comb begin
    fin_c = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (|rx_keep_s[i]) fin_c = IDX_W'(i);
    end
  end

  // Buffer registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      idx_q   <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
      idx_q   <= idx_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state: step through slices, reload on the final slice when a word waits.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    user_d      = user_q;
    idx_d       = idx_q;
    fin_d       = fin_q;
    rx_tready_c = 1'b0;

    case (state_q)
      EMPTY: begin
        rx_tready_c = 1'b1;
      end
      EMIT: begin
        if (tx_tready) begin
          if (idx_q != fin_q) begin
            idx_d = IDX_W'(idx_q + 1'b1);
          end else begin
            rx_tready_c = 1'b1;
            if (!rx_tvalid) state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (rx_tready_c && rx_tvalid) begin
      state_d = EMIT;
      data_d  = rx_tdata;
      keep_d  = rx_tkeep;
      last_d  = rx_tlast;
      user_d  = rx_tuser;
      idx_d   = '0;
      fin_d   = fin_c;
    end
  end

  assign rx_tready = rx_tready_c && !areset;
  assign tx_tvalid = (state_q == EMIT);
  assign tx_tdata  = data_s[idx_q];
  assign tx_tkeep  = keep_s[idx_q];
  assign tx_tlast  = last_q && (idx_q == fin_q);
  assign tx_tuser  = user_q;

endmodule

// File: tb/tb_logic_axi4_stream_downsizer.sv
// Scoreboard bench for logic_axi4_stream_downsizer (8-byte in, 2-byte out).
module tb_logic_axi4_stream_downsizer;

  localparam int unsigned IB = 8;
  localparam int unsigned OB = 2;
  localparam int unsigned TU = 1;
  localparam int unsigned EW = 8*OB + OB + 1 + TU;

  logic          clk = 1'b0;
  logic          areset;
  logic          rx_tvalid;
  logic          rx_tready;
  logic [8*IB-1:0] rx_tdata;
  logic [IB-1:0] rx_tkeep;
  logic          rx_tlast;
  logic [TU-1:0] rx_tuser;
  logic          tx_tvalid;
  logic          tx_tready;
  logic [8*OB-1:0] tx_tdata;
  logic [OB-1:0] tx_tkeep;
  logic          tx_tlast;
  logic [TU-1:0] tx_tuser;

  bit            rnd_en = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            hs_count = 0;
  int unsigned   cyc = 0;
  logic [EW-1:0] sb[$];

  always #5 clk = ~clk;

  logic_axi4_stream_downsizer #(
    .TARGET         (logic_pkg::TARGET_GENERIC),
    .TDATA_BYTES_IN (IB),
    .TDATA_BYTES_OUT(OB),
    .TUSER_WIDTH    (TU)
  ) dut (
    .aclk     (clk),
    .areset   (areset),
    .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready),
    .rx_tdata (rx_tdata),
    .rx_tkeep (rx_tkeep),
    .rx_tlast (rx_tlast),
    .rx_tuser (rx_tuser),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .tx_tdata (tx_tdata),
    .tx_tkeep (tx_tkeep),
    .tx_tlast (tx_tlast),
    .tx_tuser (tx_tuser)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: constant high, or random when stalling is exercised.
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected slice on each TX handshake, checks stability while stalled.
  initial begin
    logic          held;
    logic [EW-1:0] held_val;
    logic [EW-1:0] cur;
    logic [EW-1:0] exp;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      cur = {tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
      if (areset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 64'(tx_tvalid), 64'd1);
          check("stall_payload", 64'(cur), 64'(held_val));
        end
        if (tx_tvalid && tx_tready) begin
          hs_count++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_slice: got 0x%0h expected none", cur);
          end else begin
            exp = sb.pop_front();
            check("slice", 64'(cur), 64'(exp));
          end
        end
        held = tx_tvalid && !tx_tready;
        held_val = cur;
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [1:0] k, input logic l, input logic [TU-1:0] u);
    sb.push_back({d, k, l, u});
  endtask

  // Small reference split: slices 0..F, F = highest slice with nonzero keep.
  task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [TU-1:0] u);
    int f;
    logic [15:0] ds;
    logic [1:0]  ks;
    f = 0;
    for (int i = 0; i < 4; i++) begin
      ks = k[2*i +: 2];
      if (ks != 2'b00) f = i;
    end
    for (int i = 0; i <= f; i++) begin
      ds = d[16*i +: 16];
      ks = k[2*i +: 2];
      push(ds, ks, l && (i == f), u);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic [TU-1:0] u, output int waited);
    logic hs;
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    rx_tkeep  = k;
    rx_tlast  = l;
    rx_tuser  = u;
    waited = 0;
    hs = 1'b0;
    while (!hs) begin
      @(negedge clk);
      hs = rx_tready;
      waited++;
      @(posedge clk);
      #1;
      if (!hs && waited >= 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_accept_timeout: got no rx_tready expected handshake");
        break;
      end
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n0;
    int unsigned c0;
    areset    = 1'b1;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    rx_tkeep  = '0;
    rx_tlast  = 1'b0;
    rx_tuser  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tdata",  64'(tx_tdata),  64'd0);
    check("rst_tkeep",  64'(tx_tkeep),  64'd0);
    check("rst_tlast",  64'(tx_tlast),  64'd0);
    check("rst_tuser",  64'(tx_tuser),  64'd0);
    check("rst_rx_tready", 64'(rx_tready), 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("rx_tready_after_rst", 64'(rx_tready), 64'd1);
    @(posedge clk);
    #1;

    // Full word, four slices, tlast on the last
    push(16'h2211, 2'h3, 1'b0, 1'b0);
    push(16'h4433, 2'h3, 1'b0, 1'b0);
    push(16'h6655, 2'h3, 1'b0, 1'b0);
    push(16'h8877, 2'h3, 1'b1, 1'b0);
    send(64'h8877_6655_4433_2211, 8'hFF, 1'b1, 1'b0, w);
    @(negedge clk);
    check("latency_tvalid", 64'(tx_tvalid), 64'd1);
    check("latency_tdata",  64'(tx_tdata),  64'h2211);
    wait_drain();

    // Half keep: two slices
    push(16'h2211, 2'h3, 1'b0, 1'b0);
    push(16'h4433, 2'h3, 1'b1, 1'b0);
    send(64'h8877_6655_4433_2211, 8'h0F, 1'b1, 1'b0, w);
    wait_drain();

    // All-zero keep: single null slice with tlast
    push(16'hDDDD, 2'h0, 1'b1, 1'b0);
    send(64'hAAAA_BBBB_CCCC_DDDD, 8'h00, 1'b1, 1'b0, w);
    wait_drain();

    // Null slices below F are still emitted
    push(16'h0102, 2'h0, 1'b0, 1'b0);
    push(16'h0304, 2'h0, 1'b0, 1'b0);
    push(16'h0506, 2'h3, 1'b1, 1'b0);
    send(64'h0708_0506_0304_0102, 8'h30, 1'b1, 1'b0, w);
    wait_drain();

    // Three back-to-back words: 12 contiguous slices, accept every 4 cycles
    push_word(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0);
    push_word(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0);
    push_word(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1, 1'b0);
    send(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0, w);
    n0 = hs_count;
    c0 = cyc;
    send(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0, w);
    check("b2b_gap_word2", 64'(w), 64'd4);
    send(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1, 1'b0, w);
    check("b2b_gap_word3", 64'(w), 64'd4);
    while (cyc < c0 + 12) begin
      @(posedge clk);
      #1;
    end
    check("b2b_contiguous", 64'(hs_count - n0), 64'd12);
    wait_drain();

    // Random sink stalls, tuser carried on every slice
    rnd_en = 1'b1;
    push_word(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0, 1'b1);
    push_word(64'h0123_4567_89AB_CDEF, 8'h3F, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0, 1'b1, w);
    send(64'h0123_4567_89AB_CDEF, 8'h3F, 1'b1, 1'b1, w);
    wait_drain();
    rnd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after slice 1: remaining slices dropped
    push_word(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b0);
    send(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b0, w);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", 64'(tx_tvalid), 64'd0);
    check("midrst_tlast",  64'(tx_tlast),  64'd0);
    check("midrst_tkeep",  64'(tx_tkeep),  64'd0);
    check("midrst_rx_tready", 64'(rx_tready), 64'd1);
    check("midrst_dropped", 64'(sb.size()), 64'd2);
    sb.delete();
    @(posedge clk);
    #1;
    push_word(64'hAB00_CD00_EF00_1200, 8'hFF, 1'b1, 1'b1);
    send(64'hAB00_CD00_EF00_1200, 8'hFF, 1'b1, 1'b1, w);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
